microwave_mode_fsm: RTL and testbench

Top-level operating-mode state machine for the microwave controller. It consumes debounced single-cycle button pulses, the door switch and the remaining cook time, and produces the 3-bit `mode` code. The button/time-setting stage uses `mode` to decide whether to adjust or count down `run_time`, and feeds `run_time` back here. It also drives the magnetron/turntable enable, the cavity lamp and the end-of-cook buzzer.

---
 rtl/microwave_mode_fsm.sv | 107 ++++++++++
 tb/tb_microwave_mode_fsm.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/microwave_mode_fsm.sv
// Microwave operating-mode FSM: IDLE/SET/RUN/STOP/FINISH, lamp, motor and end-of-cook beeper.
// Latency: 1 cycle, all outputs registered. Backpressure: none, button pulses are consumed on the cycle they arrive.
module microwave_mode_fsm #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FINISH_SEC = 3,
  parameter int BEEP_HZ    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnL,
  input  logic        btnC,
  input  logic        btnD,
  input  logic        door_open,
  input  logic [13:0] run_time,
  output logic [2:0]  mode,
  output logic        motor_en,
  output logic        lamp_on,
  output logic        buzzer
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SET    = 3'b001,
    RUN    = 3'b010,
    STOP   = 3'b011,
    FINISH = 3'b100
  } mode_t;

  localparam logic [31:0] FIN_LAST  = 32'(FINISH_SEC * CLK_HZ - 1);
  localparam logic [31:0] BEEP_LAST = 32'(CLK_HZ / (2 * BEEP_HZ) - 1);

  mode_t       state_q;
  mode_t       state_d;
  logic [31:0] fin_cnt;
  logic [31:0] beep_cnt;
  logic        rt_zero;

  // Up/down buttons only matter to the time-setting stage.
  logic unused_btns;
  assign unused_btns = btnU ^ btnD;

  assign rt_zero = (run_time == '0);
  assign mode    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (btnC) state_d = SET;
      end
      SET: begin
        if (btnL)                             state_d = IDLE;
        else if (btnC && !rt_zero && !door_open) state_d = RUN;
      end
      RUN: begin
        if (door_open)    state_d = STOP;
        else if (btnL)    state_d = IDLE;
        else if (btnC)    state_d = STOP;
        else if (rt_zero) state_d = FINISH;
      end
      STOP: begin
        if (btnL)                   state_d = IDLE;
        else if (btnC && !door_open) state_d = rt_zero ? FINISH : RUN;
      end
      FINISH: begin
        if (btnC || btnL)           state_d = IDLE;
        else if (fin_cnt == FIN_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      motor_en <= 1'b0;
      lamp_on  <= 1'b0;
      buzzer   <= 1'b0;
      fin_cnt  <= '0;
      beep_cnt <= '0;
    end else begin
      state_q  <= state_d;
      motor_en <= (state_d == RUN);
      lamp_on  <= door_open | (state_d == RUN);
      if (state_d == FINISH && state_q == FINISH) begin
        fin_cnt <= fin_cnt + 32'd1;
        if (beep_cnt == BEEP_LAST) begin
          beep_cnt <= '0;
          buzzer   <= ~buzzer;
        end else begin
          beep_cnt <= beep_cnt + 32'd1;
        end
      end else if (state_d == FINISH) begin
        // Fresh entry: beeper starts high with both counters at zero.
        fin_cnt  <= '0;
        beep_cnt <= '0;
        buzzer   <= 1'b1;
      end else begin
        fin_cnt  <= '0;
        beep_cnt <= '0;
        buzzer   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_microwave_mode_fsm.sv
// Bench for microwave_mode_fsm with a shortened clock rate (CLK_HZ=100).
module tb_microwave_mode_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        btnU = 1'b0, btnL = 1'b0, btnC = 1'b0, btnD = 1'b0, door_open = 1'b0;
  logic [13:0] run_time = '0;
  logic [2:0]  mode;
  logic        motor_en, lamp_on, buzzer;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  microwave_mode_fsm #(.CLK_HZ(100), .FINISH_SEC(3), .BEEP_HZ(2)) dut (
    .clk(clk), .reset(reset), .btnU(btnU), .btnL(btnL), .btnC(btnC), .btnD(btnD),
    .door_open(door_open), .run_time(run_time), .mode(mode), .motor_en(motor_en),
    .lamp_on(lamp_on), .buzzer(buzzer)
  );

  typedef struct {
    logic        l, c, d;
    logic [13:0] rt;
    logic [2:0]  m;
    logic        mo, la, bz;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic l, input logic c, input logic d, input logic [13:0] rt,
                              input logic [2:0] m, input logic mo, input logic la, input logic bz);
    vec_t v;
    v.l = l; v.c = c; v.d = d; v.rt = rt; v.m = m; v.mo = mo; v.la = la; v.bz = bz;
    return v;
  endfunction

  // Compared as {mode, motor_en, lamp_on, buzzer}.
  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {mode, motor_en, lamp_on, buzzer};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got mode/motor/lamp/buzz=%b required=%b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic l, input logic c, input logic d, input logic [13:0] rt);
    @(negedge clk);
    btnL = l; btnC = c; door_open = d; run_time = rt;
    @(posedge clk);
    #1;
    btnL = 1'b0; btnC = 1'b0;
  endtask

  initial begin
    //           L     C     door  rt     mode    mot   lamp  buz
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,  3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,  3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 14'd0,  3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,  3'b000, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,  3'b000, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd30, 3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b1, 14'd30, 3'b001, 1'b0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd30, 3'b010, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 14'd30, 3'b010, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd30, 3'b011, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,  3'b100, 1'b0, 1'b0, 1'b1));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,  3'b000, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd60, 3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd60, 3'b010, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b1, 14'd60, 3'b011, 1'b0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b1, 14'd60, 3'b011, 1'b0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd60, 3'b010, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 14'd60, 3'b000, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd60, 3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd60, 3'b010, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd60, 3'b011, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 14'd60, 3'b000, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd60, 3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd60, 3'b010, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 14'd60, 3'b000, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd5,  3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd5,  3'b010, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 14'd0,  3'b100, 1'b0, 1'b0, 1'b1));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,  3'b000, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd5,  3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd5,  3'b010, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b1, 14'd5,  3'b011, 1'b0, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b1, 14'd5,  3'b000, 1'b0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 14'd5,  3'b000, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 14'd5,  3'b001, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 14'd5,  3'b000, 1'b0, 1'b0, 1'b0));

    reset = 1'b0;
    #2;
    check("reset_state", 6'b000_0_0_0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].l, vq[i].c, vq[i].d, vq[i].rt);
      check($sformatf("vec%0d", i), {vq[i].m, vq[i].mo, vq[i].la, vq[i].bz});
    end

    // Auto-exit from FINISH with the beeper toggling every 25 cycles.
    step(1'b0, 1'b1, 1'b0, 14'd5);
    step(1'b0, 1'b1, 1'b0, 14'd5);
    check("fin_pre_run", 6'b010_1_1_0);
    step(1'b0, 1'b0, 1'b0, 14'd0);
    check("fin_entry", 6'b100_0_0_1);
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 1'b0, 1'b0, 14'd0);
      if (k < 300)
        check($sformatf("fin_k%0d", k), {3'b100, 1'b0, 1'b0, ((k / 25) % 2 == 0) ? 1'b1 : 1'b0});
      else
        check("fin_auto_exit", 6'b000_0_0_0);
    end

    // Asynchronous reset mid-cook, between clock edges.
    step(1'b0, 1'b1, 1'b0, 14'd5);
    step(1'b0, 1'b1, 1'b0, 14'd5);
    check("rst_pre_run", 6'b010_1_1_0);
    #3 reset = 1'b0;
    #2 check("rst_async_run", 6'b000_0_0_0);
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 14'd5);
    check("rst_resume_idle", 6'b000_0_0_0);
    step(1'b0, 1'b1, 1'b0, 14'd5);
    check("rst_resume_set", 6'b001_0_0_0);

    // Asynchronous reset while beeping.
    step(1'b0, 1'b1, 1'b0, 14'd5);
    step(1'b0, 1'b0, 1'b0, 14'd0);
    check("rst_pre_fin", 6'b100_0_0_1);
    #3 reset = 1'b0;
    #2 check("rst_async_fin", 6'b000_0_0_0);
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 14'd0);
    check("rst_fin_idle", 6'b000_0_0_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
